// File: rtl/instr_cycle_sequencer_if.sv
// Control-side bundle for the instruction-cycle sequencer.
// The slave side is the sequencer. The master side drives the decode feedback and strobes.
interface instr_cycle_sequencer_if #(
    parameter int T_WIDTH = 8,
    parameter int SC_W    = (T_WIDTH > 1) ? $clog2(T_WIDTH) : 1
);
    logic               start;
    logic [15:0]        ir;
    logic               hlt;
    logic               ien_set;
    logic               ien_clr;
    logic               fgi;
    logic               fgo;
    logic [T_WIDTH-1:0] T;
    logic [7:0]         D;
    logic               I;
    logic               R;
    logic               ien;
    logic               running;
    logic [SC_W-1:0]    sc;

    modport slave (
        input  start, ir, hlt, ien_set, ien_clr, fgi, fgo,
        output T, D, I, R, ien, running, sc
    );

    modport master (
        output start, ir, hlt, ien_set, ien_clr, fgi, fgo,
        input  T, D, I, R, ien, running, sc
    );
endinterface

// File: rtl/instr_cycle_sequencer.sv
// Basic-computer instruction cycle sequencer: SC/T timing, D/I decode latch,
// run flop S, interrupt enable IEN and interrupt-cycle flag R.
module instr_cycle_sequencer #(
    parameter int T_WIDTH      = 8,
    parameter bit RUN_AT_RESET = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instr_cycle_sequencer_if.slave  bus
);
    localparam int SC_W = (T_WIDTH > 1) ? $clog2(T_WIDTH) : 1;

    typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} run_e;
    localparam run_e RUN_RST = RUN_AT_RESET ? ST_RUN : ST_STOP;

    run_e             run_q, run_d;
    logic [SC_W-1:0]  sc_q, sc_d;
    logic [7:0]       d_q, d_d;
    logic             i_q, i_d;
    logic             r_q, r_d;
    logic             ien_q, ien_d;

    logic [T_WIDTH-1:0] t_vec;
    logic [7:0]         t;
    logic               halt, sc_last, sc_clr, irq;
    logic               unused_ir;

    assign unused_ir = ^bus.ir[11:0];

    // t is a fixed 8-wide view so the clear terms can name T0..T7 for any T_WIDTH
    always_comb begin
        t_vec = '0;
        t     = '0;
        if (run_q == ST_RUN) begin
            for (int k = 0; k < T_WIDTH; k++) t_vec[k] = (int'(sc_q) == k);
            for (int k = 0; k < 8; k++)       t[k]     = (int'(sc_q) == k);
        end
    end

    assign halt    = bus.hlt & t[3];
    assign sc_last = (int'(sc_q) == T_WIDTH - 1);
    assign sc_clr  = (r_q & t[2])
                   | (d_q[7] & t[3])
                   | ((d_q[3] | d_q[4]) & t[4])
                   | ((d_q[0] | d_q[1] | d_q[2] | d_q[5]) & t[5])
                   | (d_q[6] & t[6])
                   | halt
                   | sc_last;

    // Interrupt may only be taken outside fetch/decode, and never on a halting edge
    assign irq = (run_q == ST_RUN) & ~r_q & ien_q & (bus.fgi | bus.fgo)
               & ~(t[0] | t[1] | t[2]) & ~halt;

    always_comb begin
        run_d = run_q;
        sc_d  = sc_q;
        d_d   = d_q;
        i_d   = i_q;
        r_d   = r_q;
        ien_d = ien_q;

        if (bus.ien_set) ien_d = 1'b1;
        if (bus.ien_clr) ien_d = 1'b0;

        if (run_q == ST_STOP) begin
            if (bus.start) run_d = ST_RUN;
        end else begin
            sc_d = sc_clr ? '0 : sc_q + 1'b1;
            if (halt) run_d = ST_STOP;
            if (t[2] && !r_q) begin
                d_d = 8'h01 << bus.ir[14:12];
                i_d = bus.ir[15];
            end
            if (r_q && t[2]) begin
                r_d   = 1'b0;
                ien_d = 1'b0;
            end else if (irq) begin
                r_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= RUN_RST;
            sc_q  <= '0;
            d_q   <= '0;
            i_q   <= 1'b0;
            r_q   <= 1'b0;
            ien_q <= 1'b0;
        end else begin
            run_q <= run_d;
            sc_q  <= sc_d;
            d_q   <= d_d;
            i_q   <= i_d;
            r_q   <= r_d;
            ien_q <= ien_d;
        end
    end

    assign bus.T       = t_vec;
    assign bus.D       = d_q;
    assign bus.I       = i_q;
    assign bus.R       = r_q;
    assign bus.ien     = ien_q;
    assign bus.running = (run_q == ST_RUN);
    assign bus.sc      = sc_q;
endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Directed bench for instr_cycle_sequencer with hand-computed expectations.
module tb_instr_cycle_sequencer;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    instr_cycle_sequencer_if #(.T_WIDTH(8)) bus ();

    instr_cycle_sequencer #(.T_WIDTH(8), .RUN_AT_RESET(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at T0 of the instruction; ends at T0 of the following one
    task automatic run_instr(input string tag, input logic [15:0] w, input int n,
                             input logic [7:0] de, input logic ie);
        logic [7:0] te;
        bus.ir = w;
        chk({tag, "_t0"}, bus.T, 8'h01);
        for (int k = 1; k < n; k++) begin
            step();
            te = 8'h01 << k;
            chk({tag, "_sc"}, bus.sc, k);
            chk({tag, "_t"}, bus.T, te);
            if (k == 3) begin
                chk({tag, "_d"}, bus.D, de);
                chk({tag, "_i"}, bus.I, ie);
            end
        end
        step();
        chk({tag, "_end_sc"}, bus.sc, 0);
        chk({tag, "_end_t"}, bus.T, 8'h01);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 0; bus.ir = 16'h0000; bus.hlt = 0;
        bus.ien_set = 0; bus.ien_clr = 0; bus.fgi = 0; bus.fgo = 0;

        #3;
        chk("rst_t", bus.T, 8'h00);
        chk("rst_d", bus.D, 8'h00);
        chk("rst_run", bus.running, 0);
        chk("rst_sc", bus.sc, 0);
        chk("rst_r", bus.R, 0);
        chk("rst_ien", bus.ien, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_run", bus.running, 0);
        chk("idle_t", bus.T, 8'h00);

        // LDA direct
        bus.ir = 16'h2005;
        bus.start = 1;
        step();
        bus.start = 0;
        chk("start_run", bus.running, 1);
        run_instr("lda", 16'h2005, 6, 8'h04, 1'b0);
        run_instr("bun", 16'hC010, 5, 8'h10, 1'b1);
        run_instr("isz", 16'h6020, 7, 8'h40, 1'b0);
        run_instr("cla", 16'h7800, 4, 8'h80, 1'b0);

        // HLT at T3, with a coincident start that must lose
        bus.ir = 16'h7001;
        step(); step(); step();
        chk("hlt_d", bus.D, 8'h80);
        chk("hlt_t3", bus.T, 8'h08);
        bus.hlt = 1; bus.start = 1;
        step();
        bus.hlt = 0; bus.start = 0;
        chk("hlt_run", bus.running, 0);
        chk("hlt_t", bus.T, 8'h00);
        chk("hlt_sc", bus.sc, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("stop_sc", bus.sc, 0);
            chk("stop_t", bus.T, 8'h00);
        end
        bus.start = 1;
        step();
        bus.start = 0;
        chk("resume_run", bus.running, 1);
        chk("resume_t", bus.T, 8'h01);

        // ADD with flag raised during T4
        bus.ir = 16'h1000;
        bus.ien_set = 1;
        step();
        bus.ien_set = 0;
        chk("ion", bus.ien, 1);
        step(); step();
        chk("add_d", bus.D, 8'h02);
        step();
        chk("add_t4", bus.T, 8'h10);
        bus.fgi = 1;
        step();
        chk("irq4_r", bus.R, 1);
        chk("irq4_sc", bus.sc, 5);
        step();
        chk("irq4_end_sc", bus.sc, 0);
        chk("irq4_cyc_r", bus.R, 1);
        chk("irq4_cyc_t", bus.T, 8'h01);
        bus.fgi = 0;
        bus.ir = 16'h7800;
        step(); step();
        chk("icyc_t2", bus.T, 8'h04);
        chk("icyc_r", bus.R, 1);
        bus.ien_set = 1;
        step();
        bus.ien_set = 0;
        chk("icyc_done_r", bus.R, 0);
        chk("icyc_done_ien", bus.ien, 0);
        chk("icyc_done_sc", bus.sc, 0);
        chk("icyc_no_latch_d", bus.D, 8'h02);

        // ADD with flag raised during T1: not taken until the T3 edge
        bus.ir = 16'h1000;
        bus.ien_set = 1;
        step();
        bus.ien_set = 0;
        bus.fgi = 1;
        chk("ion2", bus.ien, 1);
        step();
        chk("irq1_t2_r", bus.R, 0);
        step();
        chk("irq1_t3_r", bus.R, 0);
        step();
        chk("irq1_t4_r", bus.R, 1);
        chk("irq1_t4_sc", bus.sc, 4);
        bus.fgi = 0;
        step(); step();
        chk("irq1_end_sc", bus.sc, 0);
        chk("irq1_cyc_r", bus.R, 1);
        step(); step(); step();
        chk("icyc2_r", bus.R, 0);
        chk("icyc2_ien", bus.ien, 0);
        chk("icyc2_sc", bus.sc, 0);

        // Set and clear together
        bus.ien_set = 1;
        step();
        chk("ien_set", bus.ien, 1);
        bus.ien_clr = 1;
        step();
        bus.ien_set = 0; bus.ien_clr = 0;
        chk("ien_both", bus.ien, 0);

        // Async reset in T4 of an indirect STA
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.ir = 16'hB000;
        bus.start = 1; bus.ien_set = 1;
        step();
        bus.start = 0; bus.ien_set = 0;
        chk("sta_run", bus.running, 1);
        chk("sta_ien", bus.ien, 1);
        step(); step(); step();
        chk("sta_d", bus.D, 8'h08);
        chk("sta_i", bus.I, 1);
        step();
        chk("sta_t4", bus.T, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_t", bus.T, 8'h00);
        chk("arst_d", bus.D, 8'h00);
        chk("arst_i", bus.I, 0);
        chk("arst_r", bus.R, 0);
        chk("arst_ien", bus.ien, 0);
        chk("arst_run", bus.running, 0);
        chk("arst_sc", bus.sc, 0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/instr_cycle_sequencer.md
Name: instr_cycle_sequencer

Overview:
- Sequences the basic-computer instruction cycle: fetch, decode, indirect, execute and interrupt.
- Owns the sequence counter (SC), the one-hot timing vector T, the registered opcode decode D, the indirect bit I, the run flip-flop S, the interrupt-enable flip-flop IEN and the interrupt-cycle flip-flop R.
- Its T, D and I outputs drive the combinational control decode directly. That decode's HLT output comes back into this block as hlt.

Parameters:
- T_WIDTH, 8, number of timing states (SC counts 0..T_WIDTH-1, SC width = clog2(T_WIDTH)).
- RUN_AT_RESET, 0, value loaded into S at reset (1 = run immediately after reset release).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; sets S when stopped.
- ir  input  16  instruction register contents (valid from the T2 cycle onward).
- hlt  input  1  halt request from control decode (asserted in D7·I'·T3 with B0).
- ien_set  input  1  ION instruction strobe.
- ien_clr  input  1  IOF instruction strobe.
- fgi  input  1  input flag.
- fgo  input  1  output flag.
- T  output  8  one-hot timing, T[SC] gated by S.
- D  output  8  one-hot opcode decode of ir[14:12], registered.
- I  output  1  indirect bit ir[15], registered.
- R  output  1  interrupt-cycle flag.
- ien  output  1  interrupt enable.
- running  output  1  S flip-flop.
- sc  output  3  raw sequence counter value.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - SC=0, D=8'h00, I=0, R=0, IEN=0, S=RUN_AT_RESET.
  - T=8'h00 while S=0; if RUN_AT_RESET=1, T=8'h01.
- T output: T = S ? (1<<SC) : 0. Exactly one bit high while running, none while stopped.
- Run control:
  - S=0: SC holds 0 and all flip-flops except IEN hold.
  - start while S=0 sets S on the edge; the next cycle shows T0.
  - start while S=1 is ignored.
- Decode latch: on the edge leaving T2 with R=0, D <= one-hot(ir[14:12]) and I <= ir[15]. D and I are valid from T3 and hold until the next T2 edge.
- SC advance: SC <= SC+1 every cycle while S=1, unless a clear condition holds; a clear sets SC <= 0.
- SC clear conditions (evaluated with the current D, I, R, T):
  - R·T2 (end of interrupt cycle).
  - D7·T3 (register-reference or I/O instruction).
  - D3·T4 (STA) and D4·T4 (BUN).
  - D0·T5, D1·T5, D2·T5, D5·T5 (AND, ADD, LDA, BSA).
  - D6·T6 (ISZ).
  - hlt·T3; in this case S is also cleared.
  - Reaching SC=T_WIDTH-1 with no clear condition is a decode error: SC wraps to 0.
- Halt: hlt·T3·S=1 → S=0 and SC=0 on that edge; T=0 from the next cycle.
- Interrupt entry:
  - R <= 1 on an edge where S=1, R=0, IEN=1, (fgi|fgo)=1, and the current state is not T0, T1 or T2.
  - R entering mid-instruction does not disturb the current instruction's SC sequence or clear.
- Interrupt cycle:
  - While R=1 the control decode uses R·T0..T2 in place of fetch.
  - D and I are not latched while R=1.
  - On the R·T2 edge: R <= 0, IEN <= 0, SC <= 0.
- IEN:
  - ien_set → IEN=1; ien_clr → IEN=0.
  - Both set and clear in the same cycle → clear wins.
  - The R·T2 clear overrides ien_set.
- Simultaneous events:
  - hlt and an interrupt condition on the same edge → halt wins and R is not set.
  - start and hlt on the same edge → hlt wins.
- Reset asserted mid-instruction → immediate return to reset values; no partial state is retained.

Test Plan:
- Reset then start pulse, ir=16'h2005 (LDA, I=0):
  - T sequence 01,02,04,08,10,20 then 01.
  - D=8'h04 from T3; I=0; SC clears after T5.
- ir=16'hC010 (BUN, I=1):
  - I=1 and D=8'h10 from T3; SC goes 0..4 then 0 (5 states per instruction).
- ir=16'h6020 (ISZ):
  - SC reaches 6 (T=8'h40), then 0.
  - ir=16'h7800 (CLA, register-reference): SC 0..3 then 0.
- ir=16'h7001 with hlt driven high at T3:
  - running=0 and T=8'h00 on the next cycle; SC holds 0 for 10 cycles.
  - A start pulse resumes at T0.
- IEN=1 via ien_set, fgi=1 raised during T4 of an ADD:
  - R=1 from the following cycle; the ADD still ends after T5.
  - Then T0,T1,T2 with R=1; after the R·T2 edge R=0, IEN=0, SC=0.
  - Repeat with fgi high during T1: R is not set until T3.
- rst_n pulsed low during T4 of STA: all outputs return to reset values asynchronously, without waiting for a clock edge.
- ien_set and ien_clr asserted together: IEN=0.
